// File: rtl/pipe_barrier_param.sv
// pipe_barrier_param: parametrised LC-3b pipeline-stage register.
// Carries the control word, IR, PC, valid and NUM_OPS operand channels. It
// supports stall (hold), flush (bubble) and per-channel force-load during a
// stall. Each force-loaded channel is flagged in op_patched.
// Optional feature: define PIPE_BARRIER_STALL_COUNT_EN to build a saturating
// counter of consecutive stalled cycles while valid. Without the macro,
// stall_count is constant 0.
module pipe_barrier_param #(
  parameter int CTRL_W  = 32,
  parameter int DATA_W  = 16,
  parameter int NUM_OPS = 2,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [CTRL_W-1:0]         control_in,
  input  logic [DATA_W-1:0]         ir_in,
  input  logic [DATA_W-1:0]         pc_in,
  input  logic                      valid_in,
  input  logic [NUM_OPS*DATA_W-1:0] op_in,
  input  logic [NUM_OPS-1:0]        op_force_load,
  output logic [CTRL_W-1:0]         control_out,
  output logic [DATA_W-1:0]         ir_out,
  output logic [DATA_W-1:0]         pc_out,
  output logic                      valid_out,
  output logic [NUM_OPS*DATA_W-1:0] op_out,
  output logic [NUM_OPS-1:0]        op_patched,
  output logic [CNT_W-1:0]          stall_count
);

  // ---- stage register (p1): everything below is one cycle after the inputs
  logic [CTRL_W-1:0]         ctrl_p1;
  logic [DATA_W-1:0]         ir_p1;
  logic [DATA_W-1:0]         pc_p1;
  logic                      vld_p1;
  logic [NUM_OPS*DATA_W-1:0] op_p1;
  logic [NUM_OPS-1:0]        patched_p1;

  // Stage contents: reset clears all, flush bubbles but keeps the payload,
  // advance loads everything, and stall holds except for force-loaded channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_p1    <= '0;
      ir_p1      <= '0;
      pc_p1      <= '0;
      vld_p1     <= 1'b0;
      op_p1      <= '0;
      patched_p1 <= '0;
    end else if (flush) begin
      ctrl_p1    <= '0;
      vld_p1     <= 1'b0;
      patched_p1 <= '0;
    end else if (!stall) begin
      ctrl_p1    <= control_in;
      ir_p1      <= ir_in;
      pc_p1      <= pc_in;
      vld_p1     <= valid_in;
      op_p1      <= op_in;
      patched_p1 <= '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (op_force_load[i]) begin
          op_p1[i*DATA_W +: DATA_W] <= op_in[i*DATA_W +: DATA_W];
          patched_p1[i]             <= 1'b1;
        end
      end
    end
  end

`ifdef PIPE_BARRIER_STALL_COUNT_EN
  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Count stalled edges that hold a valid instruction; any non-stall edge clears it.
  always_ff @(posedge clk) begin
    if (reset || flush || !stall) begin
      cnt_p1 <= '0;
    end else if (vld_p1) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign stall_count = cnt_p1;
`else
  assign stall_count = '0;
`endif

  assign control_out = ctrl_p1;
  assign ir_out      = ir_p1;
  assign pc_out      = pc_p1;
  assign valid_out   = vld_p1;
  assign op_out      = op_p1;
  assign op_patched  = patched_p1;

endmodule

// File: tb/tb_pipe_barrier_param.sv
// tb_pipe_barrier_param: directed bench for pipe_barrier_param. It instantiates
// a 2-channel and a 4-channel build. Expected values are hand-computed.
module tb_pipe_barrier_param;

`ifdef PIPE_BARRIER_STALL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush, valid_in;
  logic [31:0] control_in;
  logic [15:0] ir_in, pc_in;
  logic [31:0] op_in;
  logic [1:0]  op_force_load;
  logic [31:0] control_out;
  logic [15:0] ir_out, pc_out;
  logic        valid_out;
  logic [31:0] op_out;
  logic [1:0]  op_patched;
  logic [7:0]  stall_count;

  logic        stall4, flush4, valid_in4;
  logic [31:0] control_in4;
  logic [15:0] ir_in4, pc_in4;
  logic [63:0] op_in4;
  logic [3:0]  op_force_load4;
  logic [31:0] control_out4;
  logic [15:0] ir_out4, pc_out4;
  logic        valid_out4;
  logic [63:0] op_out4;
  logic [3:0]  op_patched4;
  logic [7:0]  stall_count4;

  int checks = 0;
  int errors = 0;

  pipe_barrier_param #(.CTRL_W(32), .DATA_W(16), .NUM_OPS(2), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .control_in(control_in), .ir_in(ir_in), .pc_in(pc_in), .valid_in(valid_in),
    .op_in(op_in), .op_force_load(op_force_load),
    .control_out(control_out), .ir_out(ir_out), .pc_out(pc_out),
    .valid_out(valid_out), .op_out(op_out), .op_patched(op_patched),
    .stall_count(stall_count)
  );

  pipe_barrier_param #(.CTRL_W(32), .DATA_W(16), .NUM_OPS(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .stall(stall4), .flush(flush4),
    .control_in(control_in4), .ir_in(ir_in4), .pc_in(pc_in4), .valid_in(valid_in4),
    .op_in(op_in4), .op_force_load(op_force_load4),
    .control_out(control_out4), .ir_out(ir_out4), .pc_out(pc_out4),
    .valid_out(valid_out4), .op_out(op_out4), .op_patched(op_patched4),
    .stall_count(stall_count4)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_cnt(input int k);
    if (!CNT_EN) return 8'd0;
    return (k > 255) ? 8'hFF : k[7:0];
  endfunction

  initial begin
    // 1: reset dominates stall, flush and live inputs
    reset = 1; stall = 1; flush = 1; valid_in = 1; control_in = 32'hFFFF_FFFF;
    ir_in = 16'h1357; pc_in = 16'h2468; op_in = 32'h9999_8888; op_force_load = 2'b11;
    stall4 = 1; flush4 = 0; valid_in4 = 1; control_in4 = 32'hFFFF_FFFF;
    ir_in4 = 16'hFFFF; pc_in4 = 16'hFFFF; op_in4 = 64'hFFFF_FFFF_FFFF_FFFF; op_force_load4 = 4'hF;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_ctrl", control_out, 0);
      check("rst_ir", ir_out, 0);
      check("rst_pc", pc_out, 0);
      check("rst_vld", valid_out, 0);
      check("rst_op", op_out, 0);
      check("rst_patch", op_patched, 0);
      check("rst_cnt", stall_count, 0);
      check("rst_op4", op_out4, 0);
      check("rst_patch4", op_patched4, 0);
    end

    // 2: plain advance
    reset = 0; flush = 0; stall = 0; op_force_load = 2'b00;
    control_in = 32'h0000_00A5; ir_in = 16'h1234; pc_in = 16'h0040; op_in = {16'hBBBB, 16'hAAAA};
    tick();
    check("adv_ir", ir_out, 16'h1234);
    check("adv_pc", pc_out, 16'h0040);
    check("adv_op", op_out, 32'hBBBB_AAAA);
    check("adv_vld", valid_out, 1);
    check("adv_ctrl", control_out, 32'h0000_00A5);
    check("adv_patch", op_patched, 2'b00);
    check("adv_cnt", stall_count, 0);

    // 3: patch channel 1 during a stall, hold, re-patch, then release
    stall = 1; op_force_load = 2'b10; op_in = {16'hCCCC, 16'h5555};
    ir_in = 16'hFFFF; pc_in = 16'hFFFF; valid_in = 0; control_in = 32'h0;
    tick();
    check("pat_op", op_out, 32'hCCCC_AAAA);
    check("pat_patch", op_patched, 2'b10);
    check("pat_ir", ir_out, 16'h1234);
    check("pat_pc", pc_out, 16'h0040);
    check("pat_vld", valid_out, 1);
    check("pat_ctrl", control_out, 32'h0000_00A5);
    check("pat_cnt", stall_count, exp_cnt(1));
    op_force_load = 2'b00; op_in = {16'h1111, 16'h2222};
    tick();
    check("hold_op", op_out, 32'hCCCC_AAAA);
    check("hold_patch", op_patched, 2'b10);
    check("hold_cnt", stall_count, exp_cnt(2));
    op_force_load = 2'b10; op_in = {16'hDDDD, 16'h6666};
    tick();
    check("repat_op", op_out, 32'hDDDD_AAAA);
    check("repat_patch", op_patched, 2'b10);
    stall = 0; op_force_load = 2'b00; valid_in = 1; control_in = 32'h0000_005A;
    ir_in = 16'h2345; pc_in = 16'h0042; op_in = {16'h3333, 16'h4444};
    tick();
    check("rel_op", op_out, 32'h3333_4444);
    check("rel_patch", op_patched, 2'b00);
    check("rel_ir", ir_out, 16'h2345);
    check("rel_cnt", stall_count, 0);

    // 4: flush beats stall and force-load
    stall = 1; flush = 1; op_force_load = 2'b11; op_in = {16'hEEEE, 16'hFFFF};
    tick();
    check("fl_vld", valid_out, 0);
    check("fl_ctrl", control_out, 0);
    check("fl_op", op_out, 32'h3333_4444);
    check("fl_patch", op_patched, 0);
    check("fl_ir", ir_out, 16'h2345);
    check("fl_pc", pc_out, 16'h0042);
    // force-load while invalid still patches; counter does not move
    flush = 0; op_force_load = 2'b01; op_in = {16'h0000, 16'h7777};
    tick();
    check("inv_op", op_out, 32'h3333_7777);
    check("inv_patch", op_patched, 2'b01);
    check("inv_vld", valid_out, 0);
    check("inv_cnt", stall_count, 0);

    // 5: long valid stall, counter saturates, advance clears
    stall = 0; op_force_load = 2'b00; valid_in = 1;
    tick();
    check("cnt_pre_vld", valid_out, 1);
    stall = 1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      check($sformatf("cnt_%0d", k), stall_count, exp_cnt(k));
    end
    stall = 0;
    tick();
    check("cnt_clear", stall_count, 0);

    // 6: four-channel build, patch channel 3 only
    stall4 = 0; op_force_load4 = 4'h0; op_in4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tick();
    check("w4_adv_op", op_out4, 64'h4444_3333_2222_1111);
    stall4 = 1; op_force_load4 = 4'b1000; op_in4 = {16'hDEAD, 16'h9999, 16'h9999, 16'h9999};
    tick();
    check("w4_ch3", op_out4[63:48], 16'hDEAD);
    check("w4_ch012", op_out4[47:0], 48'h3333_2222_1111);
    check("w4_patch", op_patched4, 4'b1000);
    check("w4_vld", valid_out4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_barrier_param.md
Name: pipe_barrier_param

Overview:
- Parametrised pipeline-stage register for the LC-3b pipeline, next generation of the per-stage barrier.
- Carries control word, IR, PC, valid and NUM_OPS operand channels.
- Adds a squash/flush input, per-channel force-load during stall, per-channel "patched" flags, and an optional stall-occupancy counter.
- Intended to replace per-stage hand-written barriers between ID/EX, EX/MEM and MEM/WB.

Parameters:
- CTRL_W, 32, width of control word.
- DATA_W, 16, width of IR, PC and each operand channel.
- NUM_OPS, 2, number of operand channels; legal range 1..4.
- CNT_W, 8, width of the stall counter (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the stage contents.
- flush  in  1  squash the stage contents to a bubble.
- control_in  in  CTRL_W  control word from the previous stage.
- ir_in  in  DATA_W  instruction register.
- pc_in  in  DATA_W  program counter.
- valid_in  in  1  incoming instruction is valid.
- op_in  in  NUM_OPS*DATA_W  operand channels, channel i = bits [i*DATA_W +: DATA_W].
- op_force_load  in  NUM_OPS  per-channel load enable that overrides stall.
- control_out  out  CTRL_W  registered control word.
- ir_out  out  DATA_W  registered IR.
- pc_out  out  DATA_W  registered PC.
- valid_out  out  1  registered valid.
- op_out  out  NUM_OPS*DATA_W  registered operands.
- op_patched  out  NUM_OPS  channel i was force-loaded during the current stall.
- stall_count  out  CNT_W  consecutive stalled cycles while valid (optional feature).

Behaviour:
- All outputs drive registers directly; no combinational input-to-output path. Latency is 1 cycle.
- Reset (any cycle, regardless of stall or flush) clears every register: control, ir, pc, ops, valid, op_patched and stall_count all become 0.
- Priority per edge: reset > flush > advance/stall.
- Flush, stall ignored:
  - valid <= 0, control <= 0, op_patched <= 0, stall_count <= 0.
  - ir, pc and ops hold their values.
  - op_force_load is ignored on the flush edge.
- Advance (stall=0, no flush):
  - control, ir, pc, valid and all ops load from their inputs.
  - op_patched <= 0; stall_count <= 0.
- Stall (stall=1, no flush):
  - control, ir, pc and valid hold.
  - For each channel i with op_force_load[i]=1: op[i] <= op_in[i] and op_patched[i] <= 1.
  - Channels with op_force_load[i]=0 hold their op and op_patched values.
  - Repeated force-loads in the same stall overwrite op[i]; op_patched[i] stays 1.
- op_force_load during advance has no extra effect, since the channel loads anyway and op_patched is cleared.
- Stall while valid_out=0 is still honoured as a hold. A force-load while invalid still updates the op and sets op_patched.

Optional Feature:
- Macro: PIPE_BARRIER_STALL_COUNT_EN.
- Defined:
  - stall_count increments by 1 on each stall edge with valid_out=1 and no flush.
  - Saturates at 2^CNT_W-1.
  - Holds (no increment) on a stall edge with valid_out=0.
  - Cleared on advance, flush and reset.
- Undefined:
  - stall_count is tied to constant 0 and no counter logic is synthesised.
  - Port list is unchanged.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with valid_in=1, control_in=32'hFFFF_FFFF, stall=1, flush=1 -> all outputs 0 after the first edge and stay 0.
2. Advance: stall=0, valid_in=1, ir_in=16'h1234, pc_in=16'h0040, op_in={16'hBBBB,16'hAAAA} -> next cycle ir_out=16'h1234, pc_out=16'h0040, op_out={16'hBBBB,16'hAAAA}, valid_out=1, op_patched=2'b00.
3. Patch in stall: after test 2, stall=1, op_force_load=2'b10, op_in={16'hCCCC,16'h5555} -> op_out={16'hCCCC,16'hAAAA}, op_patched=2'b10, ir/pc/valid unchanged. Release the stall with new inputs -> op_patched=2'b00.
4. Flush vs stall: valid_out=1, stall=1, flush=1, op_force_load=2'b11 -> valid_out=0, control_out=0, ops unchanged, op_patched=0.
5. Stall counter (macro defined, CNT_W=8): valid_out=1, stall=1 for 300 cycles -> stall_count reads 1..255 and saturates at 8'hFF. One advance edge -> stall_count=0. Macro undefined -> stall_count=0 throughout.
6. NUM_OPS=4 build: force-load channel 3 only during stall with 16'hDEAD -> op_out[63:48]=16'hDEAD, op_patched=4'b1000, channels 0-2 unchanged.
